// File: rtl/trax_pkg.sv
// Shared constants for the Trax move parser: ASCII codes, tile codes,
// move-word field offsets and the parser state encoding.
package trax_pkg;

  localparam int MOVE_W   = 22;
  localparam int TILE_LSB = 20;
  localparam int COL_LSB  = 10;
  localparam int ROW_LSB  = 0;

  typedef enum logic [1:0] {
    TILE_NONE   = 2'b00,
    TILE_PLUS   = 2'b01,
    TILE_SLASH  = 2'b10,
    TILE_BSLASH = 2'b11
  } tile_e;

  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_PLUS   = 8'h2B;
  localparam logic [7:0] CH_DASH   = 8'h2D;
  localparam logic [7:0] CH_SLASH  = 8'h2F;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_NINE   = 8'h39;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_A      = 8'h41;
  localparam logic [7:0] CH_B_UP   = 8'h42;
  localparam logic [7:0] CH_W_UP   = 8'h57;
  localparam logic [7:0] CH_Z      = 8'h5A;
  localparam logic [7:0] CH_BSLASH = 8'h5C;
  localparam logic [7:0] CH_B_LO   = 8'h62;
  localparam logic [7:0] CH_W_LO   = 8'h77;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLOR,
    ST_COL,
    ST_ROW,
    ST_SYNC
  } state_e;

endpackage

// File: rtl/trax_ascii_classify.sv
// Combinational byte classifier. o_value carries the digit value, the letter
// value (A=1..Z=26) or the 2-bit tile code, depending on the class.
module trax_ascii_classify
  import trax_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic       o_is_digit,
  output logic       o_is_letter,
  output logic       o_is_tile,
  output logic       o_is_eol,
  output logic       o_is_space,
  output logic [4:0] o_value
);

  always_comb begin
    o_is_digit  = (i_byte >= CH_ZERO) && (i_byte <= CH_NINE);
    o_is_letter = (i_byte >= CH_A) && (i_byte <= CH_Z);
    o_is_tile   = (i_byte == CH_PLUS) || (i_byte == CH_SLASH) || (i_byte == CH_BSLASH);
    o_is_eol    = (i_byte == CH_CR) || (i_byte == CH_LF);
    o_is_space  = (i_byte == CH_SPACE);
    o_value     = '0;
    if (o_is_digit) begin
      o_value = 5'(i_byte - CH_ZERO);
    end else if (o_is_letter) begin
      o_value = 5'(i_byte - CH_AT);
    end else if (i_byte == CH_PLUS) begin
      o_value = {3'b000, TILE_PLUS};
    end else if (i_byte == CH_SLASH) begin
      o_value = {3'b000, TILE_SLASH};
    end else if (i_byte == CH_BSLASH) begin
      o_value = {3'b000, TILE_BSLASH};
    end
  end

endmodule

// File: rtl/trax_move_parser.sv
// Parses ASCII Trax notation and colour lines into {tile, col, row} move words.
// Optional TRAX_PARSER_BOUNDS_CHECK_EN rejects out-of-range coordinates at termination.
module trax_move_parser
  import trax_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int MAX_ROW     = 20,
  parameter int MAX_COL     = 20,
  parameter int MAX_DIGITS  = 3,
  parameter int MAX_LETTERS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [2*COORD_W+1:0]   move,
  output logic                   move_valid,
  output logic                   color,
  output logic                   color_valid,
  output logic                   parse_err
);

  localparam int ACC_W = COORD_W + 4;

  logic             w_is_digit;
  logic             w_is_letter;
  logic             w_is_tile;
  logic             w_is_eol;
  logic             w_is_space;
  logic [4:0]       w_value;

  state_e           r_state,  w_state_next;
  logic [ACC_W-1:0] r_col,    w_col_next;
  logic [ACC_W-1:0] r_row,    w_row_next;
  logic [3:0]       r_nlet,   w_nlet_next;
  logic [3:0]       r_ndig,   w_ndig_next;
  logic [2*COORD_W+1:0] r_move, w_move_next;
  logic             r_move_valid,  w_move_valid_next;
  logic             r_color,       w_color_next;
  logic             r_color_valid, w_color_valid_next;
  logic             r_parse_err,   w_parse_err_next;

  trax_ascii_classify u_classify (
    .i_byte      (rx_data),
    .o_is_digit  (w_is_digit),
    .o_is_letter (w_is_letter),
    .o_is_tile   (w_is_tile),
    .o_is_eol    (w_is_eol),
    .o_is_space  (w_is_space),
    .o_value     (w_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_nlet        <= '0;
      r_ndig        <= '0;
      r_move        <= '0;
      r_move_valid  <= 1'b0;
      r_color       <= 1'b0;
      r_color_valid <= 1'b0;
      r_parse_err   <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_col         <= w_col_next;
      r_row         <= w_row_next;
      r_nlet        <= w_nlet_next;
      r_ndig        <= w_ndig_next;
      r_move        <= w_move_next;
      r_move_valid  <= w_move_valid_next;
      r_color       <= w_color_next;
      r_color_valid <= w_color_valid_next;
      r_parse_err   <= w_parse_err_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_col_next         = r_col;
    w_row_next         = r_row;
    w_nlet_next        = r_nlet;
    w_ndig_next        = r_ndig;
    w_move_next        = r_move;
    w_move_valid_next  = 1'b0;
    w_color_next       = r_color;
    w_color_valid_next = 1'b0;
    w_parse_err_next   = 1'b0;

    if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_space || w_is_eol) begin
            w_state_next = ST_IDLE;
          end else if (rx_data == CH_DASH) begin
            w_state_next = ST_COLOR;
          end else if (rx_data == CH_AT) begin
            w_col_next   = '0;
            w_row_next   = '0;
            w_ndig_next  = '0;
            w_state_next = ST_ROW;
          end else if (w_is_letter) begin
            w_col_next   = ACC_W'(w_value);
            w_nlet_next  = 4'd1;
            w_row_next   = '0;
            w_ndig_next  = '0;
            w_state_next = ST_COL;
          end else begin
            w_parse_err_next = 1'b1;
            w_state_next     = ST_SYNC;
          end
        end

        ST_COLOR: begin
          // The colour line end is swallowed by SYNC, same as after an error.
          w_state_next = ST_SYNC;
          if (rx_data == CH_W_UP || rx_data == CH_W_LO) begin
            w_color_next       = 1'b0;
            w_color_valid_next = 1'b1;
          end else if (rx_data == CH_B_UP || rx_data == CH_B_LO) begin
            w_color_next       = 1'b1;
            w_color_valid_next = 1'b1;
          end else begin
            w_parse_err_next = 1'b1;
          end
        end

        ST_COL: begin
          if (w_is_letter && (r_nlet < 4'(MAX_LETTERS))) begin
            w_col_next  = ACC_W'((r_col * 26) + w_value);
            w_nlet_next = r_nlet + 4'd1;
          end else if (w_is_digit) begin
            w_row_next   = ACC_W'(w_value);
            w_ndig_next  = 4'd1;
            w_state_next = ST_ROW;
          end else begin
            w_parse_err_next = 1'b1;
            w_state_next     = ST_SYNC;
          end
        end

        ST_ROW: begin
          if (w_is_digit && (r_ndig < 4'(MAX_DIGITS))) begin
            w_row_next  = ACC_W'((r_row * 10) + w_value);
            w_ndig_next = r_ndig + 4'd1;
          end else if (w_is_tile) begin
            w_state_next = ST_IDLE;
`ifdef TRAX_PARSER_BOUNDS_CHECK_EN
            if ((r_row > ACC_W'(MAX_ROW)) || (r_col > ACC_W'(MAX_COL))) begin
              w_parse_err_next = 1'b1;
            end else begin
              w_move_next       = {w_value[1:0], r_col[COORD_W-1:0], r_row[COORD_W-1:0]};
              w_move_valid_next = 1'b1;
            end
`else
            w_move_next       = {w_value[1:0], r_col[COORD_W-1:0], r_row[COORD_W-1:0]};
            w_move_valid_next = 1'b1;
`endif
          end else begin
            w_parse_err_next = 1'b1;
            w_state_next     = ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (rx_data == CH_LF) begin
            w_state_next = ST_IDLE;
          end
        end

        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign move        = r_move;
  assign move_valid  = r_move_valid;
  assign color       = r_color;
  assign color_valid = r_color_valid;
  assign parse_err   = r_parse_err;

endmodule

// File: tb/tb_trax_move_parser.sv
// Scoreboard bench for trax_move_parser: expected move/colour/error events are
// queued as each line is driven and matched against the output pulses.
module tb_trax_move_parser;
  import trax_pkg::*;

  localparam logic [1:0] KIND_MOVE  = 2'd1;
  localparam logic [1:0] KIND_COLOR = 2'd2;
  localparam logic [1:0] KIND_ERR   = 2'd3;

  typedef struct packed {
    logic [1:0]        kind;
    logic [MOVE_W-1:0] val;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic [MOVE_W-1:0] move;
  logic              move_valid;
  logic              color;
  logic              color_valid;
  logic              parse_err;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  trax_move_parser dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .move        (move),
    .move_valid  (move_valid),
    .color       (color),
    .color_valid (color_valid),
    .parse_err   (parse_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t ev_move(input logic [1:0] tile, input int col, input int row);
    exp_t e;
    e.kind = KIND_MOVE;
    e.val  = (MOVE_W'(tile) << TILE_LSB) | (MOVE_W'(col) << COL_LSB) | (MOVE_W'(row) << ROW_LSB);
    return e;
  endfunction

  function automatic exp_t ev_color(input logic c);
    exp_t e;
    e.kind = KIND_COLOR;
    e.val  = MOVE_W'(c);
    return e;
  endfunction

  function automatic exp_t ev_err();
    exp_t e;
    e.kind = KIND_ERR;
    e.val  = '0;
    return e;
  endfunction

  task automatic take(input logic [1:0] kind, input logic [MOVE_W-1:0] val, input string tag);
    exp_t e;
    check({tag, "_expected"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      $display("txn %s val=0x%0h expected kind=%0d val=0x%0h", tag, val, e.kind, e.val);
      check({tag, "_kind"}, 32'(kind), 32'(e.kind));
      if (e.kind == kind && kind != KIND_ERR) check({tag, "_val"}, 32'(val), 32'(e.val));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (move_valid)  take(KIND_MOVE, move, "move");
      if (color_valid) take(KIND_COLOR, MOVE_W'(color), "color");
      if (parse_err)   take(KIND_ERR, '0, "err");
    end
  end

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(posedge clk);
      #1;
      rx_data  = s[i];
      rx_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({tag, "_drained"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_move", 32'(move), 32'd0);
    check("rst_color", 32'(color), 32'd0);
    check("rst_pulses", {29'd0, move_valid, color_valid, parse_err}, 32'd0);

    q.push_back(ev_move(TILE_PLUS, 0, 0));
    send("@0+");
    drain("t1");

    q.push_back(ev_move(TILE_SLASH, 2, 3));
    send("B3/");
    drain("t2");

    q.push_back(ev_move(TILE_BSLASH, 28, 12));
    send("AB12\\");
    drain("t3");

    q.push_back(ev_color(1'b1));
    send("-B\n");
    q.push_back(ev_color(1'b0));
    send("-w\n");
    drain("t4");
    check("t4_move_held", 32'(move), 32'h0030700C);
    check("t4_color_held", 32'(color), 32'd0);

`ifdef TRAX_PARSER_BOUNDS_CHECK_EN
    q.push_back(ev_err());
`else
    q.push_back(ev_move(TILE_PLUS, 3, 25));
`endif
    send("C25+");
    drain("t5");

    send(" \r\n");
    drain("ws");

    q.push_back(ev_err());
    send("x\n");
    q.push_back(ev_err());
    send("-q\n");
    q.push_back(ev_err());
    send("ABC1+\n");
    drain("errs");

    q.push_back(ev_color(1'b1));
    send("-b\n");
    send("B");
    @(posedge clk);
    #1;
    reset    = 1'b1;
    rx_data  = CH_PLUS;
    rx_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    check("t6_rst_move", 32'(move), 32'd0);
    check("t6_rst_color", 32'(color), 32'd0);
    q.push_back(ev_err());
    q.push_back(ev_move(TILE_PLUS, 1, 1));
    send("3/\nA1+");
    drain("t6");

    q.push_back(ev_err());
    send("A1234+");
    drain("t7a");
    q.push_back(ev_move(TILE_PLUS, 1, 1));
    send("\nA1+");
    drain("t7b");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
